// File: rtl/gclk_tick_gen_pkg.sv
// Shared timing constants and speed-switch state encoding for the
// Game Boy clock consumer, the divider and the CPU timing code.
package gclk_tick_gen_pkg;

  localparam int T_PHASES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    STALL = 3'd2,
    APPLY = 3'd3,
    DONE  = 3'd4
  } switch_state_t;

  // Next T-state index, wrapping after the last T-state of an M-cycle
  function automatic logic [1:0] next_phase(input logic [1:0] phase);
    if (phase == 2'(T_PHASES - 1)) begin
      return 2'd0;
    end
    return phase + 2'd1;
  endfunction

endpackage

// File: rtl/gclk_tick_gen_edge_sync.sv
// gclk_edge_sync: brings a slow clock-like level into the sclk domain
// through a 2-flop synchronizer plus a history flop, and produces
// registered one-cycle strobes for its rising and falling edges.
// Works for any input whose high and low times are each at least
// two sclk cycles.
module gclk_edge_sync (
  input  logic sclk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize the input and register the level-change strobes
  always_ff @(posedge sclk) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/gclk_tick_gen.sv
// gclk_tick_gen: turns the divided Game Boy clock into T-state and
// M-cycle clock enables in the sclk domain, and sequences the CGB
// speed switch by driving cgb_mode back into the divider.
// Optional build macro GCLK_WDOG_EN adds a gclk watchdog with a sticky
// gclk_fault output that also blocks cpu_en.
module gclk_tick_gen
  import gclk_tick_gen_pkg::*;
#(
  parameter int SWITCH_STALL_M = 2050,
  parameter int STALL_W        = 12
`ifdef GCLK_WDOG_EN
  ,
  parameter int WDOG_LIMIT     = 64
`endif
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       gclk,
  input  logic       switch_req,
  output logic       cgb_mode,
  output logic       t_rise,
  output logic       t_fall,
  output logic [1:0] t_phase,
  output logic       m_strobe,
  output logic       cpu_en,
  output logic       switch_busy,
  output logic       switch_ack
`ifdef GCLK_WDOG_EN
  ,
  output logic       gclk_fault
`endif
);

  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(SWITCH_STALL_M - 1);

  logic [1:0]         phase_q;
  switch_state_t      state_q;
  switch_state_t      state_n;
  logic [STALL_W-1:0] cnt_q;
  logic [STALL_W-1:0] cnt_n;
  logic               mode_q;
  logic               mode_n;
  logic               cpu_ok;

  gclk_edge_sync u_edge_sync (
    .sclk (sclk),
    .rst  (rst),
    .din  (gclk),
    .rise (t_rise),
    .fall (t_fall)
  );

  assign t_phase  = phase_q;
  assign m_strobe = t_rise & (phase_q == 2'(T_PHASES - 1));

  // T-phase counter advances once per gclk rising edge
  always_ff @(posedge sclk) begin
    if (!rst) begin
      phase_q <= 2'd0;
    end else if (t_rise) begin
      phase_q <= next_phase(phase_q);
    end
  end

  // Speed-switch state, stall counter and speed select registers
  always_ff @(posedge sclk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mode_q  <= mode_n;
    end
  end

  // Speed-switch sequencing: align to an M-cycle, stall, flip speed, ack
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    case (state_q)
      IDLE: begin
        if (switch_req) begin
          state_n = ALIGN;
        end
      end
      ALIGN: begin
        if (m_strobe) begin
          state_n = STALL;
          cnt_n   = STALL_LOAD;
        end
      end
      STALL: begin
        if (m_strobe) begin
          if (cnt_q == '0) begin
            state_n = APPLY;
          end else begin
            cnt_n = cnt_q - STALL_W'(1);
          end
        end
      end
      APPLY: begin
        mode_n  = ~mode_q;
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign cgb_mode    = mode_q;
  assign switch_busy = (state_q != IDLE);
  assign switch_ack  = (state_q == DONE);

`ifdef GCLK_WDOG_EN
  logic [7:0] wd_q;
  logic [7:0] wd_n;
  logic       fault_q;

  // Watchdog count: cleared by any gclk edge, otherwise saturating
  always_comb begin
    wd_n = wd_q;
    if (t_rise | t_fall) begin
      wd_n = 8'd0;
    end else if (wd_q != 8'hFF) begin
      wd_n = wd_q + 8'd1;
    end
  end

  // Watchdog register and sticky fault, cleared only by reset
  always_ff @(posedge sclk) begin
    if (!rst) begin
      wd_q    <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      wd_q <= wd_n;
      if (wd_n == 8'(WDOG_LIMIT)) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign gclk_fault = fault_q;
  assign cpu_ok     = ~fault_q;
`else
  assign cpu_ok = 1'b1;
`endif

  assign cpu_en = m_strobe & (state_q == IDLE) & cpu_ok;

endmodule

// File: tb/tb_gclk_tick_gen.sv
// tb_gclk_tick_gen: directed bench for gclk_tick_gen. Models the clock
// divider (normal: 3 high / 3 low, double: 2 high / 1 low) and checks
// reset state, strobe latency and spacing, the speed switch, reset during
// a switch, ignored requests while busy, and the optional watchdog
// (built with GCLK_WDOG_EN).
module tb_gclk_tick_gen;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       gclk = 1'b0;
  logic       switch_req = 1'b0;
  logic       cgb_mode;
  logic       t_rise;
  logic       t_fall;
  logic [1:0] t_phase;
  logic       m_strobe;
  logic       cpu_en;
  logic       switch_busy;
  logic       switch_ack;
`ifdef GCLK_WDOG_EN
  logic       gclk_fault;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dcnt = 0;
  int rise_step = -1;
  int last_rise = 0;
  int last_m = -1;
  int prev_m = -1;
  int ack_count = 0;
  int ack_before = 0;
  int mc = 0;
  int en = 0;
  int n = 0;
  bit hold = 1'b0;

  // 25 MHz system clock
  always #20 sclk = ~sclk;

  gclk_tick_gen #(
    .SWITCH_STALL_M (4),
    .STALL_W        (12)
`ifdef GCLK_WDOG_EN
    ,
    .WDOG_LIMIT     (64)
`endif
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .gclk        (gclk),
    .switch_req  (switch_req),
    .cgb_mode    (cgb_mode),
    .t_rise      (t_rise),
    .t_fall      (t_fall),
    .t_phase     (t_phase),
    .m_strobe    (m_strobe),
    .cpu_en      (cpu_en),
    .switch_busy (switch_busy),
    .switch_ack  (switch_ack)
`ifdef GCLK_WDOG_EN
    ,
    .gclk_fault  (gclk_fault)
`endif
  );

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (step %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One sclk cycle: observe after the edge, then drive rst/req and the divider model
  task automatic applyStimulus(input logic r, input logic req);
    int  period;
    int  hi;
    bit  newg;
    @(posedge sclk);
    #5;
    cyc++;
    if (m_strobe) begin
      prev_m = last_m;
      last_m = cyc;
    end
    if (switch_ack) ack_count++;
    rst        = r;
    switch_req = req;
    if (!r) begin
      dcnt = 0;
      gclk = 1'b0;
    end else if (hold) begin
      gclk = 1'b1;
    end else begin
      period = cgb_mode ? 3 : 6;
      hi     = cgb_mode ? 2 : 3;
      dcnt   = (dcnt + 1 >= period) ? 0 : dcnt + 1;
      newg   = (dcnt >= period - hi);
      if (newg && !gclk) rise_step = cyc;
      gclk = newg;
    end
  endtask

  task automatic step();
    applyStimulus(1'b1, 1'b0);
  endtask

  task automatic waitRise(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!t_rise && k < 30);
    if (!t_rise) checkOutput(tag, 0, 1);
  endtask

  task automatic waitM(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_strobe && k < 60);
    if (!m_strobe) checkOutput(tag, 0, 1);
  endtask

  task automatic runToAck();
    mc = 0;
    en = 0;
    n  = 0;
    while (!switch_ack && n < 400) begin
      if (m_strobe) mc++;
      if (cpu_en) en++;
      step();
      n++;
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset held with a request asserted: request must be ignored
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_t_rise", t_rise, 0);
    checkOutput("rst_t_fall", t_fall, 0);
    checkOutput("rst_t_phase", t_phase, 0);
    checkOutput("rst_m_strobe", m_strobe, 0);
    checkOutput("rst_cpu_en", cpu_en, 0);
    checkOutput("rst_cgb_mode", cgb_mode, 0);
    checkOutput("rst_busy", switch_busy, 0);
    checkOutput("rst_ack", switch_ack, 0);
`ifdef GCLK_WDOG_EN
    checkOutput("rst_fault", gclk_fault, 0);
`endif
    step();
    step();
    checkOutput("req_in_reset_ignored", switch_busy, 0);

    // Normal speed: latency, phase sequence, rise/fall spacing
    for (int i = 1; i <= 4; i++) begin
      waitRise("t_rise_timeout");
      if (i == 1) checkOutput("rise_latency", cyc - rise_step, 3);
      else        checkOutput("rise_period", cyc - last_rise, 6);
      last_rise = cyc;
      checkOutput("m_strobe_at_rise", m_strobe, (i == 4) ? 1 : 0);
      checkOutput("cpu_en_at_rise", cpu_en, (i == 4) ? 1 : 0);
      step();
      checkOutput("rise_width", t_rise, 0);
      checkOutput("t_phase_after_rise", t_phase, i % 4);
      step();
      step();
      checkOutput("fall_after_rise", t_fall, 1);
    end
    waitM("m_timeout_normal");
    checkOutput("m_period_normal", last_m - prev_m, 24);

    // Speed switch to double speed
    applyStimulus(1'b1, 1'b1);
    step();
    checkOutput("busy_after_req", switch_busy, 1);
    runToAck();
    checkOutput("ack_seen", switch_ack, 1);
    checkOutput("stall_m_strobes", mc, 5);
    checkOutput("cpu_en_during_switch", en, 0);
    checkOutput("cgb_mode_at_ack", cgb_mode, 1);
    step();
    checkOutput("ack_width", switch_ack, 0);
    checkOutput("busy_after_ack", switch_busy, 0);
    repeat (3) waitM("m_timeout_double");
    checkOutput("m_period_double", last_m - prev_m, 12);
    checkOutput("cpu_en_double", cpu_en, 1);

    // Reset in the middle of STALL
    applyStimulus(1'b1, 1'b1);
    step();
    waitM("m_timeout_align");
    waitM("m_timeout_stall");
    checkOutput("busy_in_stall", switch_busy, 1);
    ack_before = ack_count;
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("midrst_busy", switch_busy, 0);
    checkOutput("midrst_cgb_mode", cgb_mode, 0);
    checkOutput("midrst_t_phase", t_phase, 0);
    checkOutput("midrst_ack", switch_ack, 0);
    repeat (150) step();
    checkOutput("midrst_no_ack", ack_count - ack_before, 0);
    checkOutput("midrst_cgb_stays", cgb_mode, 0);
    checkOutput("midrst_busy_stays", switch_busy, 0);

    // Second request during STALL is ignored
    ack_before = ack_count;
    applyStimulus(1'b1, 1'b1);
    step();
    waitM("m_timeout_align2");
    waitM("m_timeout_stall2");
    applyStimulus(1'b1, 1'b1);
    runToAck();
    checkOutput("busy_req_ack_seen", switch_ack, 1);
    repeat (200) step();
    checkOutput("single_ack", ack_count - ack_before, 1);
    checkOutput("single_toggle", cgb_mode, 1);
    checkOutput("idle_after_busy_req", switch_busy, 0);

`ifdef GCLK_WDOG_EN
    // Watchdog: hold gclk high, fault must latch and block cpu_en
    hold = 1'b1;
    repeat (30) step();
    checkOutput("wdog_no_fault_early", gclk_fault, 0);
    repeat (40) step();
    checkOutput("wdog_fault_set", gclk_fault, 1);
    hold = 1'b0;
    mc = 0;
    en = 0;
    repeat (100) begin
      step();
      if (m_strobe) mc++;
      if (cpu_en) en++;
    end
    checkOutput("wdog_strobes_resume", (mc > 0) ? 1 : 0, 1);
    checkOutput("wdog_cpu_en_blocked", en, 0);
    checkOutput("wdog_fault_sticky", gclk_fault, 1);
    applyStimulus(1'b0, 1'b0);
    step();
    checkOutput("wdog_fault_cleared", gclk_fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gclk_tick_gen.md
Name: gclk_tick_gen

Overview:
- Consumer end of the system-clock divider. Samples the divided Game Boy clock in the sclk domain and turns it into single-cycle T-state strobes, a 2-bit T-phase and M-cycle strobes. Core logic uses these as clock enables; it is never clocked by gclk directly.
- Owns the CGB speed-switch sequence. It drives the cgbMode select back into the divider, which closes the loop.

Parameters:
- SWITCH_STALL_M, 2050: M-cycles the CPU is stalled during a speed switch.
- STALL_W, 12: width of the stall counter. Must satisfy 2^STALL_W > SWITCH_STALL_M.
- WDOG_LIMIT, 64: sclk cycles without a gclk edge before a fault is raised. Used only with GCLK_WDOG_EN.

Ports:
- sclk  in  1  system clock, the only clock
- rst  in  1  reset, synchronous, active-low
- gclk  in  1  divided clock from the divider; asynchronous-safe input
- switch_req  in  1  1-cycle request to toggle speed (CPU STOP with KEY1 armed)
- cgb_mode  out  1  speed select to the divider; 1 = double speed
- t_rise  out  1  1-cycle strobe per gclk rising edge
- t_fall  out  1  1-cycle strobe per gclk falling edge
- t_phase  out  2  T-state index within the M-cycle, 0..3
- m_strobe  out  1  1-cycle strobe marking the start of an M-cycle
- cpu_en  out  1  m_strobe gated off while a switch is in progress
- switch_busy  out  1  high from request acceptance until ack
- switch_ack  out  1  1-cycle pulse when the switch completes
- gclk_fault  out  1  watchdog flag; present only with GCLK_WDOG_EN

Behaviour:
- Reset (rst=0 at a sclk edge): all outputs 0, t_phase=0, state IDLE, sync flops 0. Reset overrides everything, including a switch in progress. cgb_mode returns to 0 (normal speed).
- Sync chain:
  - gclk passes through 2 flops (s1, s2); s3 = previous s2.
  - t_rise is registered from s2&~s3; t_fall from ~s2&s3.
  - Latency: t_rise is high for exactly 1 sclk cycle, 3 sclk edges after gclk rises.
  - No edge is ever dropped as long as the gclk high and low times are each ≥2 sclk cycles.
- T-phase:
  - Advances on t_rise only: 3 wraps to 0.
  - m_strobe is asserted in the same cycle as the t_rise that moves t_phase to 0.
  - The first t_rise after reset yields t_phase=1, so the first m_strobe occurs on the 4th t_rise.
- cpu_en = m_strobe & (state==IDLE).
- Switch FSM:
  - IDLE: on switch_req → ALIGN; switch_busy goes to 1 on the next edge.
  - ALIGN: wait for m_strobe → STALL; stall counter loaded with SWITCH_STALL_M-1.
  - STALL: counter decrements on each m_strobe. On an m_strobe with counter==0 → APPLY.
  - APPLY (1 cycle): cgb_mode toggles → DONE.
  - DONE (1 cycle): switch_ack=1, switch_busy→0, → IDLE.
  - switch_req outside IDLE is ignored (no queueing). switch_req in the same cycle as reset is ignored.
- After cgb_mode changes, the divider's period changes. Strobes continue without a gap or a duplicate because edge detection is level-based.
- Counter arithmetic: unsigned, STALL_W bits, never underflows.

Optional Feature:
- Macro: GCLK_WDOG_EN.
- With the macro:
  - An STALL_W-independent 8-bit counter clears on t_rise or t_fall and otherwise increments, saturating.
  - When the count reaches WDOG_LIMIT, gclk_fault sets sticky until reset.
  - cpu_en is forced to 0 while gclk_fault=1.
- Without the macro: the gclk_fault port and counter are absent, and cpu_en is as above.

Decomposition:
- Shared package: speed-switch state enum (IDLE, ALIGN, STALL, APPLY, DONE) and the T_PHASES=4 constant. The divider and CPU timing code import the same constants.
- One natural sub-module: gclk_edge_sync (3-flop synchronizer plus registered rise/fall strobes). Reusable for any slow-clock input.

Test Plan:
- Normal speed: 25 MHz sclk with the divider in normal mode (gclk high 3 sclk, low 3 sclk) → t_rise every 6 sclk, t_fall 3 sclk after each t_rise, m_strobe every 24 sclk.
- Latency: gclk rises between edges n and n+1 → t_rise high in the cycle after edge n+3, width 1. The first 3 t_rise give t_phase 1,2,3; the 4th gives 0 with m_strobe=1.
- Speed switch with SWITCH_STALL_M=4:
  - Pulse switch_req → switch_busy=1.
  - cpu_en stays 0 for the next aligned m_strobe plus 4 m_strobes.
  - cgb_mode goes to 1, then switch_ack pulses once.
  - Afterwards m_strobe comes every 12 sclk (gclk period 3).
- Reset mid-STALL: rst=0 for 1 cycle → state IDLE, cgb_mode=0, switch_busy=0, t_phase=0, no switch_ack ever pulsed.
- Request while busy: second switch_req during STALL → ignored; exactly one ack and one cgb_mode toggle.
- GCLK_WDOG_EN with WDOG_LIMIT=64: hold gclk=1 for 70 sclk → gclk_fault=1 at count 64, cpu_en=0. The fault stays set after gclk resumes, until rst=0.
